buffer_consumer: RTL and testbench
==================================

BUFFER_CONSUMER -- requirements
Module: buffer_consumer

Interface
REQ-001 SHALL have parameter: HOLD_TICKS, default 4, clk cycles each word is held with data_2_valid high (legal range 1..65535).
REQ-002 SHALL have port: clk  input  1  consumer-domain clock; all logic on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: buffer_empty  input  1  buffer has no readable word.
REQ-005 SHALL have port: rd_data  input  16  buffer read data, valid the cycle after rd_en.
REQ-006 SHALL have port: drain  input  1  single-cycle (edge-detected) request to report buffer drained.
REQ-007 SHALL have port: rd_en  output  1  buffer read strobe, one cycle per word.
REQ-008 SHALL have port: data_2  output  16  word presented to the display module.
REQ-009 SHALL have port: data_2_valid  output  1  data_2 currently held for display.
REQ-010 SHALL have port: drained  output  1  one-cycle pulse: drain request satisfied.
REQ-011 SHALL have port: word_cnt  output  16  count of words consumed since reset.
REQ-012 SHALL have port: busy  output  1  high whenever state is not S_IDLE.

Function
REQ-013 SHALL implement FSM states S_IDLE, S_REQ, S_CAPT, S_HOLD.
REQ-014 S_IDLE SHALL go to S_REQ when buffer_empty=0, else stay.
REQ-015 rd_en SHALL be 1 exactly while in S_REQ; S_REQ SHALL last one cycle, then S_CAPT.
REQ-016 S_CAPT SHALL register data_2<=rd_data, set data_2_valid=1, increment word_cnt, load hold counter with HOLD_TICKS-1, go to S_HOLD.
REQ-017 S_HOLD SHALL decrement hold counter each cycle; at counter 0 it SHALL clear data_2_valid and go to S_REQ if buffer_empty=0, else S_IDLE.
REQ-018 data_2_valid SHALL be high for exactly HOLD_TICKS consecutive cycles per word; back-to-back words SHALL have exactly 2 cycles of data_2_valid=0 (S_REQ, S_CAPT) between them.
REQ-019 data_2 SHALL retain last captured word after data_2_valid falls.
REQ-020 buffer_empty SHALL be sampled only in S_IDLE and the final S_HOLD cycle; rd_en SHALL never assert when the preceding sample was buffer_empty=1.
REQ-021 word_cnt SHALL wrap 16'hFFFF -> 16'h0000 without flag.
REQ-022 drain=1 SHALL set internal drain_pending; drain while pending SHALL have no effect.
REQ-023 drained SHALL pulse high one cycle after a cycle where drain_pending=1, state=S_IDLE, buffer_empty=1; drain_pending SHALL clear in that same edge.
REQ-024 drain asserted in a cycle already meeting REQ-023 conditions SHALL yield drained on the next cycle.
REQ-025 Consumption SHALL continue normally regardless of drain_pending.

Reset
REQ-026 On rst: state=S_IDLE, rd_en=0, data_2=0, data_2_valid=0, drained=0, word_cnt=0, busy=0, hold counter=0, drain_pending=0.
REQ-027 rst mid-operation SHALL abort immediately; the partially held word SHALL be discarded and not re-read.

Configuration
REQ-028 Macro BUFFER_CONSUMER_CHECKSUM_EN defined: SHALL add output checksum (16 bits), reset 0, updated in S_CAPT to checksum XOR rd_data, and SHALL clear to 0 on each drained pulse (same edge).
REQ-029 Macro undefined: checksum port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, buffer_empty=1 for 20 cycles -> rd_en never 1, busy=0, all outputs 0.
REQ-031 HOLD_TICKS=4, one word 16'h0015 then empty -> rd_en 1 cycle, data_2=0015 valid 4 cycles, word_cnt=1, return S_IDLE.
REQ-032 HOLD_TICKS=4, three words 1,1,2 always available -> valid windows 4 cycles each separated by 2 cycles, word_cnt=3, data_2 sequence 1,1,2.
REQ-033 drain pulse during HOLD of last word -> drained pulse exactly one cycle after state returns to S_IDLE with buffer_empty=1; second drain while pending -> single drained pulse only.
REQ-034 Preload word_cnt to FFFF by consuming 65535 words (or force), consume one more -> word_cnt=0000; rst asserted mid S_HOLD -> data_2_valid=0 same cycle as rst.
REQ-035 With BUFFER_CONSUMER_CHECKSUM_EN, words A5A5, 0F0F -> checksum=AAAA; after drained -> checksum=0000.

Source files
------------

// File: rtl/buffer_consumer.sv
`timescale 1ns/1ps
// buffer_consumer
// ---------------
// Pulls words one at a time from an upstream buffer and holds each on data_2
// (with data_2_valid high) for HOLD_TICKS clk cycles so a slow display module
// can pick it up. Also answers a "drain" request with a one-cycle "drained"
// pulse once the consumer is idle and the buffer is empty.
//
// Parameters:
//   HOLD_TICKS   cycles each word is held with data_2_valid high (1..65535)
//
// Ports:
//   clk          consumer clock, rising edge
//   rst          asynchronous, active-high reset
//   buffer_empty buffer has no readable word
//   rd_data      buffer read data, valid the cycle after rd_en
//   drain        request (rising edge) to report the buffer drained
//   rd_en        buffer read strobe, one cycle per word
//   data_2       word presented to the display
//   data_2_valid data_2 currently held for display
//   drained      one-cycle pulse: drain request satisfied
//   word_cnt     words consumed since reset (wraps silently)
//   busy         consumer is not idle
//   checksum     (only with BUFFER_CONSUMER_CHECKSUM_EN) running XOR of
//                captured words, cleared on every drained pulse
//
// Build option: define BUFFER_CONSUMER_CHECKSUM_EN to add the checksum output.

module buffer_consumer #(
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        buffer_empty,
  input  logic [15:0] rd_data,
  input  logic        drain,
  output logic        rd_en,
  output logic [15:0] data_2,
  output logic        data_2_valid,
  output logic        drained,
  output logic [15:0] word_cnt,
  output logic        busy
`ifdef BUFFER_CONSUMER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_TICKS - 1);

  logic [1:0]  state;
  logic [15:0] hold_cnt;
  logic        drain_pending;
  logic        drain_q;
  logic        drain_rise;
  logic        drain_done;

  assign rd_en = (state == S_REQ);
  assign busy  = (state != S_IDLE);

  // drain is treated as an edge so a level held for several cycles still
  // counts as one request.
  assign drain_rise = drain & ~drain_q;

  // A request arriving in a cycle that already satisfies the idle/empty
  // condition is honoured directly, without first parking in drain_pending.
  assign drain_done = (drain_pending | drain_rise) & (state == S_IDLE) & buffer_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      data_2        <= 16'h0000;
      data_2_valid  <= 1'b0;
      drained       <= 1'b0;
      word_cnt      <= 16'h0000;
      hold_cnt      <= 16'h0000;
      drain_pending <= 1'b0;
      drain_q       <= 1'b0;
    end else begin
      drain_q <= drain;
      drained <= drain_done;

      if (drain_done) begin
        drain_pending <= 1'b0;
      end else if (drain_rise) begin
        drain_pending <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (!buffer_empty) begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          state <= S_CAPT;
        end
        S_CAPT: begin
          data_2       <= rd_data;
          data_2_valid <= 1'b1;
          word_cnt     <= word_cnt + 16'd1;
          hold_cnt     <= HOLD_LOAD;
          state        <= S_HOLD;
        end
        S_HOLD: begin
          // buffer_empty is only looked at in the final hold cycle, so a
          // word that arrives mid-hold is picked up without an idle gap.
          if (hold_cnt == 16'h0000) begin
            data_2_valid <= 1'b0;
            state        <= buffer_empty ? S_IDLE : S_REQ;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BUFFER_CONSUMER_CHECKSUM_EN
  // Clearing on drain_done cannot collide with a capture: drain_done
  // requires S_IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= 16'h0000;
    end else if (drain_done) begin
      checksum <= 16'h0000;
    end else if (state == S_CAPT) begin
      checksum <= checksum ^ rd_data;
    end
  end
`endif

endmodule

// File: tb/tb_buffer_consumer.sv
`timescale 1ns/1ps
// Testbench for buffer_consumer: directed vector table, hand-written timing
// sequences, and randomized traffic compared every cycle against a
// behavioural model. The model describes each word's service as a window of
// HOLD_TICKS+2 cycles (read strobe, capture, then the hold cycles).

module tb_buffer_consumer;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        buffer_empty;
  logic [15:0] rd_data;
  logic        drain;
  logic        rd_en;
  logic [15:0] data_2;
  logic        data_2_valid;
  logic        drained;
  logic [15:0] word_cnt;
  logic        busy;
`ifdef BUFFER_CONSUMER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  buffer_consumer #(.HOLD_TICKS(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .buffer_empty (buffer_empty),
    .rd_data      (rd_data),
    .drain        (drain),
    .rd_en        (rd_en),
    .data_2       (data_2),
    .data_2_valid (data_2_valid),
    .drained      (drained),
    .word_cnt     (word_cnt),
    .busy         (busy)
`ifdef BUFFER_CONSUMER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;

  // Upstream buffer contents
  logic [15:0] buf_q[$];

  // Reference model: m_pos = -1 when idle, otherwise the cycle index within
  // the current word's service window (0 = read strobe, 1 = capture,
  // 2..H+1 = word on display).
  int          m_pos;
  logic [15:0] m_data;
  logic [15:0] m_cnt;
  logic        m_drained;
  logic        m_pend;
  logic        m_drain_prev;
  logic [15:0] m_csum;
  bit          model_on;

  typedef struct {
    bit          push;
    logic [15:0] word;
    int          run;
    logic [15:0] exp_data;
    logic [15:0] exp_cnt;
    logic        exp_valid;
    logic        exp_busy;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] b2b_words[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos        = -1;
    m_data       = 16'h0000;
    m_cnt        = 16'h0000;
    m_drained    = 1'b0;
    m_pend       = 1'b0;
    m_drain_prev = 1'b0;
    m_csum       = 16'h0000;
  endtask

  task automatic push(input logic [15:0] w);
    buf_q.push_back(w);
    buffer_empty = 1'b0;
  endtask

  // One clock cycle: sample inputs before the edge, advance the model and
  // the buffer after it, then compare all outputs against the model.
  task automatic tick();
    logic        pre_rd_en;
    logic        pre_empty;
    logic [15:0] pre_rd;
    logic        pre_drain;
    logic        rise;
    logic [35:0] exp_pack;
    pre_rd_en = rd_en;
    pre_empty = buffer_empty;
    pre_rd    = rd_data;
    pre_drain = drain;
    @(posedge clk);
    #1;
    rise         = pre_drain & ~m_drain_prev;
    m_drain_prev = pre_drain;
    m_drained    = (m_pend | rise) && (m_pos < 0) && pre_empty;
    if (m_drained) begin
      m_pend = 1'b0;
      m_csum = 16'h0000;
    end else if (rise) begin
      m_pend = 1'b1;
    end
    if (m_pos == 1) begin
      m_data = pre_rd;
      m_cnt  = m_cnt + 16'd1;
      m_csum = m_csum ^ pre_rd;
    end
    if (m_pos < 0 || m_pos == H + 1) m_pos = pre_empty ? -1 : 0;
    else m_pos = m_pos + 1;

    if (pre_rd_en && buf_q.size() > 0) rd_data = buf_q.pop_front();
    buffer_empty = (buf_q.size() == 0);
    drain = 1'b0;

    if (model_on) begin
      exp_pack = {(m_pos == 0), (m_pos >= 2), m_drained, (m_pos >= 0), m_data, m_cnt};
      chk("model", {28'd0, rd_en, data_2_valid, drained, busy, data_2, word_cnt},
          {28'd0, exp_pack});
`ifdef BUFFER_CONSUMER_CHECKSUM_EN
      chk("model_checksum", {48'd0, checksum}, {48'd0, m_csum});
`endif
    end
  endtask

  task automatic do_reset();
    model_on     = 0;
    rst          = 1'b1;
    drain        = 1'b0;
    buf_q.delete();
    buffer_empty = 1'b1;
    rd_data      = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    model_on = 1;
  endtask

  initial begin
    int idle_t;
    int drn_t;
    int drn_n;
    bit rd_seen;
    logic exp_v;

    vecs[0] = '{1'b1, 16'h0015, 3, 16'h0015, 16'd1, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 16'h0000, 4, 16'h0015, 16'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h0001, 3, 16'h0001, 16'd2, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 4, 16'h0001, 16'd2, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'hBEEF, 7, 16'hBEEF, 16'd3, 1'b0, 1'b0};
    b2b_words[0] = 16'h0001;
    b2b_words[1] = 16'h0001;
    b2b_words[2] = 16'h0002;

    // Reset values while rst is held
    model_on     = 0;
    rst          = 1'b1;
    drain        = 1'b0;
    buffer_empty = 1'b1;
    rd_data      = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_data_2", data_2, 0);
    chk("rst_valid", data_2_valid, 0);
    chk("rst_drained", drained, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_busy", busy, 0);
`ifdef BUFFER_CONSUMER_CHECKSUM_EN
    chk("rst_checksum", checksum, 0);
`endif
    rst = 1'b0;
    model_reset();
    model_on = 1;

    // Empty buffer for 20 cycles: never reads
    rd_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_en) rd_seen = 1;
    end
    chk("idle_no_rd_en", rd_seen, 0);
    chk("idle_busy", busy, 0);

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].push) push(vecs[i].word);
      repeat (vecs[i].run) tick();
      chk($sformatf("vec%0d_data_2", i), data_2, vecs[i].exp_data);
      chk($sformatf("vec%0d_word_cnt", i), word_cnt, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_valid", i), data_2_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
    end

    // Back-to-back words: H-cycle valid windows separated by 2 idle cycles
    for (int k = 0; k < 3; k++) push(b2b_words[k]);
    for (int t = 1; t <= 3 * (H + 2) + 1; t++) begin
      tick();
      exp_v = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (t >= 3 + (H + 2) * k && t <= 2 + H + (H + 2) * k) exp_v = 1'b1;
        if (t == 3 + (H + 2) * k)
          chk($sformatf("b2b_data_%0d", k), data_2, b2b_words[k]);
      end
      chk($sformatf("b2b_valid_t%0d", t), data_2_valid, exp_v);
    end
    chk("b2b_word_cnt", word_cnt, 16'd6);
    chk("b2b_idle", busy, 0);

    // Drain during hold of the last word, plus a second drain while pending
    push(16'h0077);
    repeat (3) tick();
    drain = 1'b1;
    tick();
    tick();
    drain = 1'b1;
    tick();
    idle_t = -1;
    drn_t  = -1;
    drn_n  = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (!busy && idle_t < 0) idle_t = t;
      if (drained) begin
        drn_n++;
        if (drn_t < 0) drn_t = t;
      end
    end
    chk("drain_pulse_count", drn_n, 1);
    chk("drain_idle_seen", (idle_t > 0), 1);
    chk("drain_delay", drn_t - idle_t, 1);

    // Drain while already idle and empty: drained on the next cycle
    drain = 1'b1;
    tick();
    chk("drain_immediate", drained, 1);
    tick();
    chk("drained_one_cycle", drained, 0);

    // word_cnt wrap
    force dut.word_cnt = 16'hFFFF;
    #1;
    release dut.word_cnt;
    #1;
    m_cnt = 16'hFFFF;
    chk("wrap_preload", word_cnt, 16'hFFFF);
    push(16'h1234);
    repeat (H + 3) tick();
    chk("wrap_word_cnt", word_cnt, 16'h0000);
    chk("wrap_data_2", data_2, 16'h1234);

    // Reset in the middle of a hold: word dropped and not re-read
    push(16'h5A5A);
    repeat (4) tick();
    chk("pre_rst_valid", data_2_valid, 1);
    model_on = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", data_2_valid, 0);
    chk("rst_mid_data_2", data_2, 0);
    chk("rst_mid_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    model_on = 1;
    repeat (10) tick();
    chk("rst_no_reread", word_cnt, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0 && buf_q.size() < 4) push(16'($urandom));
      if ($urandom_range(24) == 0) drain = 1'b1;
      tick();
    end
    repeat (5 * (H + 2)) tick();

`ifdef BUFFER_CONSUMER_CHECKSUM_EN
    do_reset();
    push(16'hA5A5);
    push(16'h0F0F);
    repeat (2 * (H + 2) + 2) tick();
    chk("checksum_value", checksum, 16'hAAAA);
    drain = 1'b1;
    tick();
    chk("checksum_drained", drained, 1);
    chk("checksum_cleared", checksum, 16'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
